// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG pixel writer.
// Build option JPEG_PIXEL_RGB565_EN selects RGB565 words on a 2-byte stride; default is RGB888 on 4 bytes.
package jpeg_pkg;

    localparam int unsigned MAX_ADDR_W = 64;

`ifdef JPEG_PIXEL_RGB565_EN
    localparam int unsigned PIXEL_SHIFT = 1;
`else
    localparam int unsigned PIXEL_SHIFT = 2;
`endif

    // Address is carried at the widest supported width; the top uses its low ADDR_W bits.
    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [31:0]           data;
        logic                  last;
    } fifo_entry_t;

    function automatic logic [31:0] packPixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [31:0] word;
`ifdef JPEG_PIXEL_RGB565_EN
        logic [7:0] unusedLowBits;
        unusedLowBits = {r[2:0], g[1:0], b[2:0]};
        word = {16'h0000, r[7:3], g[7:2], b[7:3]};
`else
        word = {8'h00, r, g, b};
`endif
        return word;
    endfunction

endpackage

// File: rtl/jpeg_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is taken only when a pop happens in the same cycle.
module jpeg_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wrData,
    input  logic             pop,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic             doPush_s;
    logic             doPop_s;

    // Extra pointer MSB tells a full ring from an empty one when the index bits match.
    assign empty    = (wrPtr_r == rdPtr_r);
    assign full     = (wrPtr_r[PTR_W-1] != rdPtr_r[PTR_W-1]) &&
                      (wrPtr_r[PTR_W-2:0] == rdPtr_r[PTR_W-2:0]);
    assign doPop_s  = pop && !empty;
    assign doPush_s = push && (!full || doPop_s);
    assign rdData   = empty ? {WIDTH{1'b0}} : mem_r[rdPtr_r[PTR_W-2:0]];

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r[PTR_W-2:0]] <= wrData;
        end
    end

endmodule

// File: rtl/jpeg_pixel_writer.sv
// Turns the decoded pixel stream into clipped, addressed frame-buffer writes over a valid/ready port.
// Build option JPEG_PIXEL_RGB565_EN (see jpeg_pkg) selects the pixel packing and stride.
module jpeg_pixel_writer
    import jpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              JpegDecodeIdle,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              InEnable,
    input  logic [15:0]       InWidth,
    input  logic [15:0]       InHeight,
    input  logic [15:0]       InPixelX,
    input  logic [15:0]       InPixelY,
    input  logic [7:0]        InR,
    input  logic [7:0]        InG,
    input  logic [7:0]        InB,
    output logic              MemWrValid,
    input  logic              MemWrReady,
    output logic [ADDR_W-1:0] MemWrAddr,
    output logic [31:0]       MemWrData,
    output logic              Overflow,
    output logic              FrameDone,
    output logic [31:0]       PixelCount
);

    logic              idleD_r;
    logic              frameStart_s;
    logic [ADDR_W-1:0] baseAddr_r;

    logic              s1Keep_r;
    logic [15:0]       s1X_r;
    logic [15:0]       s1Y_r;
    logic [7:0]        s1R_r;
    logic [7:0]        s1G_r;
    logic [7:0]        s1B_r;
    logic              s1Keep_s;

    logic [31:0]       offset_s;
    logic [ADDR_W-1:0] addrSum_s;
    fifo_entry_t       s2Next_s;
    fifo_entry_t       s2Entry_r;
    logic              s2Keep_r;

    fifo_entry_t       fifoHead_s;
    logic              fifoFull_s;
    logic              fifoEmpty_s;
    logic              pop_s;
    logic              drop_s;

    logic              overflow_r;
    logic              frameDone_r;
    logic [31:0]       pixelCount_r;

    assign frameStart_s = idleD_r && !JpegDecodeIdle;

    // Idle history for frame-start detection and base-address latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idleD_r    <= 1'b1;
            baseAddr_r <= {ADDR_W{1'b0}};
        end else begin
            idleD_r <= JpegDecodeIdle;
            if (frameStart_s) begin
                baseAddr_r <= BaseAddr;
            end
        end
    end

    // MCU padding outside the image is dropped here and never reaches the FIFO.
    assign s1Keep_s = InEnable && (InPixelX < InWidth) && (InPixelY < InHeight);

    // Stage 1: capture pixel and clip decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Keep_r <= 1'b0;
            s1X_r    <= 16'd0;
            s1Y_r    <= 16'd0;
            s1R_r    <= 8'd0;
            s1G_r    <= 8'd0;
            s1B_r    <= 8'd0;
        end else begin
            s1Keep_r <= s1Keep_s;
            s1X_r    <= InPixelX;
            s1Y_r    <= InPixelY;
            s1R_r    <= InR;
            s1G_r    <= InG;
            s1B_r    <= InB;
        end
    end

    assign offset_s  = ({16'h0000, s1Y_r} * {16'h0000, InWidth}) + {16'h0000, s1X_r};
    assign addrSum_s = baseAddr_r + (ADDR_W'(offset_s) << PIXEL_SHIFT);

    // Stage-2 entry assembly.
    always_comb begin
        s2Next_s      = '0;
        s2Next_s.addr = MAX_ADDR_W'(addrSum_s);
        s2Next_s.data = packPixel(s1R_r, s1G_r, s1B_r);
        s2Next_s.last = (s1X_r == (InWidth - 16'd1)) && (s1Y_r == (InHeight - 16'd1));
    end

    // Stage 2: address/data register feeding the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Keep_r  <= 1'b0;
            s2Entry_r <= '0;
        end else begin
            s2Keep_r  <= s1Keep_r;
            s2Entry_r <= s2Next_s;
        end
    end

    assign pop_s  = !fifoEmpty_s && MemWrReady;
    assign drop_s = s2Keep_r && fifoFull_s && !pop_s;

    jpeg_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (s2Keep_r),
        .wrData (s2Entry_r),
        .pop    (pop_s),
        .rdData (fifoHead_s),
        .full   (fifoFull_s),
        .empty  (fifoEmpty_s)
    );

    if (ADDR_W < int'(MAX_ADDR_W)) begin : gAddrHi
        logic unusedAddrHi_s;
        assign unusedAddrHi_s = ^fifoHead_s.addr[MAX_ADDR_W-1:ADDR_W];
    end

    // Status: sticky overflow, completion pulse, per-frame accepted count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r   <= 1'b0;
            frameDone_r  <= 1'b0;
            pixelCount_r <= 32'd0;
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (frameStart_s) begin
                overflow_r <= 1'b0;
            end
            // A pop coinciding with frame start belongs to the new frame.
            if (frameStart_s) begin
                pixelCount_r <= {31'd0, pop_s};
            end else if (pop_s) begin
                pixelCount_r <= pixelCount_r + 32'd1;
            end
            frameDone_r <= pop_s && fifoHead_s.last;
        end
    end

    assign MemWrValid = !fifoEmpty_s;
    assign MemWrAddr  = fifoHead_s.addr[ADDR_W-1:0];
    assign MemWrData  = fifoHead_s.data;
    assign Overflow   = overflow_r;
    assign FrameDone  = frameDone_r;
    assign PixelCount = pixelCount_r;

endmodule

// File: doc/jpeg_pixel_writer.md
# jpeg_pixel_writer

Downstream stage of the JPEG decoder top: consumes the decoded pixel stream (enable, X/Y, R/G/B, image width/height) and turns it into linear frame-buffer write requests over a valid/ready memory port. The decoder has no backpressure, so the block clips the MCU padding pixels, computes byte addresses, absorbs memory stalls in a small FIFO, flags overflow, and signals frame completion.

## Interface
- FIFO_DEPTH, 16, write FIFO entries; power of two, ≥4
- ADDR_W, 32, memory address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- JpegDecodeIdle  in  1  decoder idle (1 idle, 0 running); falling edge marks frame start
- BaseAddr  in  ADDR_W  frame-buffer byte base; latched at frame start
- InEnable  in  1  pixel valid, one pixel per cycle
- InWidth, InHeight  in  16 each  image size in pixels; stable while decoder runs
- InPixelX, InPixelY  in  16 each  pixel coordinates
- InR, InG, InB  in  8 each  pixel colour
- MemWrValid  out  1  write request valid
- MemWrReady  in  1  memory accepts request
- MemWrAddr  out  ADDR_W  byte address
- MemWrData  out  32  pixel word
- Overflow  out  1  sticky: a pixel was dropped on a full FIFO
- FrameDone  out  1  one-cycle pulse, last pixel accepted by memory
- PixelCount  out  32  pixels accepted by memory this frame

## Operation
- Frame start (JpegDecodeIdle 1→0, detected with a registered copy): latch BaseAddr, clear Overflow and PixelCount; FIFO contents are not flushed.
- Stage 1 (register): capture InEnable, coordinates, colour; Keep = InEnable && X < InWidth && Y < InHeight. Pixels with X ≥ W or Y ≥ H are discarded silently (no Overflow, not counted).
- Stage 2 (register): Offset = Y*W + X (16×16 → 32-bit unsigned); Addr = BaseAddr + (Offset << S) truncated to ADDR_W; S = 2 (RGB888) or 1 (RGB565). Last = (X == W-1) && (Y == H-1). Data packed per Configuration.
- FIFO write: entry {Addr, Data, Last} when stage-2 Keep. Write is accepted if FIFO not full, or if full and a pop occurs in the same cycle. Otherwise the pixel is dropped and Overflow set.
- Memory side: first-word-fall-through; MemWrValid = FIFO non-empty; pop on MemWrValid && MemWrReady. Addr/Data held stable while Valid && !Ready.
- On each pop PixelCount += 1 (wraps at 2^32). Pop of an entry with Last=1 → FrameDone high next cycle for exactly one cycle.
- W = 0 or H = 0: every pixel clipped, no writes, no FrameDone.

## Timing
- Reset values: MemWrValid 0, MemWrAddr 0, MemWrData 0, Overflow 0, FrameDone 0, PixelCount 0; FIFO empty, pipeline cleared, latched base 0. Reset mid-frame discards all in-flight pixels.
- InEnable at cycle N → FIFO write at N+2 → MemWrValid at N+3 if FIFO was empty (3-cycle latency).
- Throughput one pixel/cycle with MemWrReady held high; FIFO never exceeds 1 entry in that case.
- Overflow sets the cycle after the dropped write; remains until next frame start or reset.
- Frame start coinciding with a pop: pop is counted after the clear (PixelCount = 1).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap-around handled by MSB compare for full/empty.

## Configuration
- JPEG_PIXEL_RGB565_EN defined: MemWrData = {16'h0000, R[7:3], G[7:2], B[7:3]}, S = 1 (2-byte stride).
- Undefined (default): MemWrData = {8'h00, R, G, B}, S = 2 (4-byte stride).

## Structure
- Shared package jpeg_pkg: pixel-word packing function, stride constant per mode, FIFO entry struct {addr, data, last}.
- One sub-module: jpeg_pixel_fifo (synchronous FWFT FIFO, parameter depth/width, push/pop/full/empty).

## Test plan
- 4×2 image, BaseAddr 0x1000, Ready=1, 8 pixels in raster order → addresses 0x1000..0x101C step 4, data {00,R,G,B}, FrameDone once after 8th pop, PixelCount 8.
- 3×3 image fed as full 8×8 MCU (64 pixels) → exactly 9 writes; pixel (7,7) produces none; FrameDone on (2,2).
- Ready=0 for 40 cycles during 20-pixel burst, FIFO_DEPTH 16 → 16 entries held, Overflow=1, drained entries in order; next frame start clears Overflow.
- FIFO full with push and pop in the same cycle → push accepted, Overflow stays 0, occupancy unchanged.
- JPEG_PIXEL_RGB565_EN build, pixel (1,0) R=0xFF G=0x80 B=0x08, Base 0 → Addr 0x2, Data 0x0000FC01.
- Assert rst mid-frame with 5 entries queued → MemWrValid 0, PixelCount 0 immediately (asynchronous); no FrameDone after release.
